// File: rtl/mux_arbiter_pkg.sv
// ============================================================================
// Module   : mux_arbiter_pkg
// Purpose  : Shared encodings for the arbitrated 2:1 operand mux front end.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_arbiter_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] ST_EMPTY  = 2'd0;
  localparam logic [1:0] ST_FULL_A = 2'd1;
  localparam logic [1:0] ST_FULL_B = 2'd2;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  typedef logic [1:0] arb_state_t;

  function automatic logic is_full(input arb_state_t st);
    return st != ST_EMPTY;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick2.sv
// ============================================================================
// Module   : rr_pick2
// Purpose  : Two-way round-robin pick; on a tie the side opposite rr_last wins.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick2
  import mux_arbiter_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic rr_last,
  input  logic en,
  output logic winner,
  output logic any
);

  always_comb begin
    winner = SEL_A;
    if (req_a && req_b) begin
      winner = ~rr_last;
    end else if (req_b) begin
      winner = SEL_B;
    end
    any = en && (req_a || req_b);
  end

endmodule

`default_nettype wire

// File: rtl/mux_arbiter_2to1.sv
// ============================================================================
// Module   : mux_arbiter_2to1
// Purpose  : Round-robin arbitrated 2:1 mux feeding a one-entry valid/ready
//            output buffer. Optional grant locking via MUX_ARBITER_LOCK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_arbiter_2to1
  import mux_arbiter_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             reset,
`ifdef MUX_ARBITER_LOCK_EN
  input  logic             lock_a,
  input  logic             lock_b,
`endif
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  output logic             gnt_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             gnt_b,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sel
);

  arb_state_t       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             rr_last_q, rr_last_d;

  logic             load;
  logic             pick_en;
  logic             req_a_eff;
  logic             req_b_eff;
  logic             winner;
  logic             grant;
  logic [WIDTH-1:0] mux_data;

`ifdef MUX_ARBITER_LOCK_EN
  logic lock_q, lock_d;
  logic lock_side_q, lock_side_d;

  // While locked, the side that does not own the lock is invisible to the pick.
  assign req_a_eff = req_a && !(lock_q && (lock_side_q == SEL_B));
  assign req_b_eff = req_b && !(lock_q && (lock_side_q == SEL_A));

  always_comb begin
    lock_d      = lock_q;
    lock_side_d = lock_side_q;
    if (grant) begin
      lock_d      = (winner == SEL_B) ? lock_b : lock_a;
      lock_side_d = winner;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_q      <= 1'b0;
      lock_side_q <= SEL_A;
    end else begin
      lock_q      <= lock_d;
      lock_side_q <= lock_side_d;
    end
  end
`else
  assign req_a_eff = req_a;
  assign req_b_eff = req_b;
`endif

  // The buffer can accept a word when empty or when it drains this cycle.
  assign load    = !is_full(state_q) || out_ready;
  assign pick_en = load && !reset;

  rr_pick2 u_pick (
    .req_a   (req_a_eff),
    .req_b   (req_b_eff),
    .rr_last (rr_last_q),
    .en      (pick_en),
    .winner  (winner),
    .any     (grant)
  );

  assign mux_data = (winner == SEL_B) ? data_b : data_a;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_EMPTY;
      data_q    <= '0;
      rr_last_q <= SEL_B;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      rr_last_q <= rr_last_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    rr_last_d = rr_last_q;
    if (grant) begin
      data_d    = mux_data;
      state_d   = (winner == SEL_B) ? ST_FULL_B : ST_FULL_A;
      rr_last_d = winner;
    end else if (load && is_full(state_q)) begin
      state_d = ST_EMPTY;
    end
  end

  always_comb begin
    gnt_a     = grant && (winner == SEL_A);
    gnt_b     = grant && (winner == SEL_B);
    out_valid = is_full(state_q);
    out_sel   = (state_q == ST_FULL_B);
    out_data  = data_q;
  end

endmodule

`default_nettype wire

// File: doc/mux_arbiter_2to1.md
Name: mux_arbiter_2to1

Overview:
- Arbitrating front end for the 32-bit 2:1 operand mux.
- Shares one mux output between two requesters, A and B, using round-robin priority.
- Registers the selected word into a one-entry output buffer with a valid/ready handshake.
- Sits between two datapath producers (e.g. register-file read port and forwarding path) and the single consumer of the muxed bus.

Parameters:
- WIDTH, 32, data width of each requester and of the output.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_a  input  1  requester A has valid data (valid of A-side handshake).
- data_a  input  WIDTH  requester A word; held stable while req_a && !gnt_a.
- gnt_a  output  1  A word accepted this cycle (ready of A-side handshake, combinational).
- req_b  input  1  requester B valid.
- data_b  input  WIDTH  requester B word.
- gnt_b  output  1  B word accepted this cycle.
- out_data  output  WIDTH  buffered muxed word.
- out_valid  output  1  out_data holds a word.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_sel  output  1  source of current out_data: 0 = A, 1 = B (the mux select, registered).

Behaviour:
- Reset (async, immediate): out_valid=0, out_data=0, out_sel=0, FSM=EMPTY, rr_last=1 (A wins the first tie).
- FSM states:
  - EMPTY: no word buffered.
  - FULL_A: buffer holds a word from A.
  - FULL_B: buffer holds a word from B.
  - out_valid = (state != EMPTY). out_sel = 1 only in FULL_B.
- load = (state==EMPTY) || out_ready. The buffer may refill in the same cycle it drains.
- Winner when load is high:
  - Only req_a → A. Only req_b → B.
  - Both requesting → the side opposite rr_last.
  - Neither → none.
- gnt_x = load && winner==x. At most one gnt per cycle; gnt_x never asserts without req_x.
- On the edge with a grant: out_data <= mux(data_a, data_b, sel=winner), state <= FULL_winner, rr_last <= winner.
- On the edge with load, no grant, and state != EMPTY (drain only): state <= EMPTY; out_data holds its value.
- Stall (out_valid && !out_ready): state, out_data, out_sel and rr_last hold; gnt_a = gnt_b = 0.
- Latency: a word granted at edge N is visible on out_data/out_valid after edge N. Throughput is one word per cycle with continuous out_ready.
- Fairness: with both sides requesting continuously and out_ready=1, grants strictly alternate. Neither side waits more than 1 grant.
- Combinational path out_ready → gnt_x is intentional. Requesters must not feed gnt back into req in the same cycle.
- Reset mid-transfer: the buffered word is dropped; no grant in a reset cycle.

Optional Feature:
- Macro: MUX_ARBITER_LOCK_EN.
- Defined: adds inputs lock_a and lock_b (1 bit each).
  - When side x is granted with lock_x=1, a lock flag is set.
  - While the flag is set, only x may be granted; the other side's req is ignored.
  - The flag clears on the first grant to x with lock_x=0, or on reset.
  - rr_last still updates normally.
- Undefined: the lock ports do not exist; behaviour is pure round robin as above.

Decomposition:
- Package mux_arbiter_pkg holds:
  - State encodings ST_EMPTY=2'd0, ST_FULL_A=2'd1, ST_FULL_B=2'd2.
  - Select constants SEL_A=1'b0, SEL_B=1'b1.
  - Default width constant DATA_W=32.
- Sub-module rr_pick2 (combinational: req_a, req_b, rr_last, en → winner, any). Reusable by later bus arbiters.
- The 2:1 data mux is the existing mux instance, driven by the winner select.

Test Plan:
- Reset then idle: out_valid=0, out_data=0, out_sel=0, gnt_a=gnt_b=0 for 5 cycles.
- Single request: req_a=1, data_a=32'h0000_0000, out_ready=1 → gnt_a=1 that cycle; next cycle out_data=32'h0, out_sel=0, out_valid=1.
- Tie and alternation: req_a=req_b=1, data_a=32'h0, data_b=32'hFFFF_FFFF, out_ready=1 for 4 cycles → grants A,B,A,B; out_data sequence 0, FFFF_FFFF, 0, FFFF_FFFF; out_sel 0,1,0,1.
- Backpressure: buffer FULL_B, out_ready=0 for 3 cycles with req_a=1 → gnt_a=0, out_data stable at FFFF_FFFF. Raise out_ready → gnt_a=1 the same cycle; next cycle out_sel=0.
- Async reset mid-stream: assert reset between edges while FULL_A → out_valid=0 immediately; after release, tie goes to A.
- With MUX_ARBITER_LOCK_EN: lock_b=1 over 3 B grants while req_a=1 → A starved. First B grant with lock_b=0 clears the flag; the next grant goes to A.
